// File: rtl/dphy_hs_lane_aligner.sv
// Multi-lane D-PHY HS byte aligner: per-lane sync hunt and bit-offset lock, lock-skew deskew FIFOs, word output.
// Optional DPHY_ALIGN_SOFT_SYNC_EN: a candidate one bit-error away from SYNC_BYTE also locks (exact match preferred).
module dphy_hs_lane_aligner #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned SKEW_MAX  = 3,
    parameter logic [7:0]  SYNC_BYTE = 8'hB8
) (
    input  logic                 byte_clk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic [LANES*8-1:0]   byte_data_i,
    output logic [LANES*8-1:0]   data_o,
    output logic                 valid_o,
    output logic                 sof_o,
    output logic [LANES*3-1:0]   offset_o,
    output logic                 err_skew_o
);
    localparam int unsigned DEPTH = SKEW_MAX + 1;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW    = $clog2(DEPTH + 1);
    localparam int unsigned CW    = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SKEW_MAX - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HUNT   = 3'd1,
        S_WAIT   = 3'd2,
        S_ACTIVE = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t             state_q;
    logic [7:0]         prev_q     [LANES];
    logic [LANES-1:0]   lock_q;
    logic [CW-1:0]      skew_cnt_q;
    logic [7:0]         mem_q      [LANES][DEPTH];
    logic [PW-1:0]      wr_ptr_q   [LANES];
    logic [PW-1:0]      rd_ptr_q   [LANES];
    logic [FW-1:0]      fill_q     [LANES];
    logic               sof_done_q;
    logic [LANES*8-1:0] data_q;
    logic               valid_q;
    logic               sof_q;
    logic [LANES*3-1:0] offset_q;
    logic               err_q;

    logic [15:0]        win_s      [LANES];
    logic [7:0]         cand_s     [LANES];
    logic [7:0]         exact_s    [LANES];
    logic [3:0]         sel_s      [LANES];
    logic [2:0]         hit_off_s  [LANES];
    logic [LANES-1:0]   hit_s;
    logic [LANES-1:0]   new_lock_s;
    logic [LANES-1:0]   push_s;
    logic               all_ready_s;
    logic               all_locked_s;
    logic               hunting_s;
    logic               pop_s;
    logic               skew_timeout_s;
    logic               flush_s;

    function automatic logic [7:0] win_byte(input logic [15:0] w, input logic [2:0] k);
        return w[k +: 8];
    endfunction

    function automatic logic [3:0] lowest_hit(input logic [7:0] m);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

`ifdef DPHY_ALIGN_SOFT_SYNC_EN
    logic [7:0] soft_s [LANES];

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction
`endif

    // Sync search over all 8 offsets per lane; candidate byte at the locked offset feeds the FIFO.
    always_comb begin
        all_ready_s = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            win_s[l]  = {byte_data_i[l*8 +: 8], prev_q[l]};
            cand_s[l] = win_byte(win_s[l], offset_q[l*3 +: 3]);
            for (int k = 0; k < 8; k++) begin
                exact_s[l][k] = (win_byte(win_s[l], 3'(k)) == SYNC_BYTE);
`ifdef DPHY_ALIGN_SOFT_SYNC_EN
                soft_s[l][k]  = (popcnt8(win_byte(win_s[l], 3'(k)) ^ SYNC_BYTE) == 4'd1);
`endif
            end
`ifdef DPHY_ALIGN_SOFT_SYNC_EN
            sel_s[l] = (|exact_s[l]) ? lowest_hit(exact_s[l]) : lowest_hit(soft_s[l]);
`else
            sel_s[l] = lowest_hit(exact_s[l]);
`endif
            hit_s[l]     = sel_s[l][3];
            hit_off_s[l] = sel_s[l][2:0];
            all_ready_s  = all_ready_s & (fill_q[l] != {FW{1'b0}});
        end
    end

    assign hunting_s      = (state_q == S_HUNT) || (state_q == S_WAIT);
    assign new_lock_s     = hit_s & ~lock_q & {LANES{hunting_s & enable_i}};
    assign all_locked_s   = &(lock_q | new_lock_s);
    assign push_s         = lock_q & {LANES{enable_i && ((state_q == S_WAIT) || (state_q == S_ACTIVE))}};
    assign pop_s          = enable_i && (state_q == S_ACTIVE) && all_ready_s;
    assign skew_timeout_s = (state_q == S_WAIT) && !all_locked_s && (skew_cnt_q == CNT_LAST);
    assign flush_s        = !enable_i || skew_timeout_s;

    // Lock FSM, deskew FIFOs and registered outputs; the enable drop overrides everything else.
    always_ff @(posedge byte_clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            lock_q     <= {LANES{1'b0}};
            skew_cnt_q <= {CW{1'b0}};
            sof_done_q <= 1'b0;
            data_q     <= {(LANES*8){1'b0}};
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            offset_q   <= {(LANES*3){1'b0}};
            err_q      <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                prev_q[l]   <= 8'h00;
                wr_ptr_q[l] <= {PW{1'b0}};
                rd_ptr_q[l] <= {PW{1'b0}};
                fill_q[l]   <= {FW{1'b0}};
            end
        end else begin
            valid_q <= pop_s;
            sof_q   <= pop_s & ~sof_done_q;
            err_q   <= enable_i & skew_timeout_s;
            data_q  <= {(LANES*8){1'b0}};
            if (pop_s) sof_done_q <= 1'b1;
            lock_q  <= lock_q | new_lock_s;
            for (int l = 0; l < LANES; l++) begin
                prev_q[l] <= byte_data_i[l*8 +: 8];
                if (new_lock_s[l]) offset_q[l*3 +: 3] <= hit_off_s[l];
                if (push_s[l]) begin
                    mem_q[l][wr_ptr_q[l]] <= cand_s[l];
                    wr_ptr_q[l]           <= next_ptr(wr_ptr_q[l]);
                end
                if (pop_s) begin
                    data_q[l*8 +: 8] <= mem_q[l][rd_ptr_q[l]];
                    rd_ptr_q[l]      <= next_ptr(rd_ptr_q[l]);
                end
                fill_q[l] <= fill_q[l] + FW'(push_s[l]) - FW'(pop_s);
                if (flush_s) begin
                    wr_ptr_q[l] <= {PW{1'b0}};
                    rd_ptr_q[l] <= {PW{1'b0}};
                    fill_q[l]   <= {FW{1'b0}};
                end
            end
            if (!enable_i) begin
                state_q    <= S_IDLE;
                lock_q     <= {LANES{1'b0}};
                sof_done_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_HUNT;
                    S_HUNT: begin
                        if (all_locked_s) begin
                            state_q <= S_ACTIVE;
                        end else if (|new_lock_s) begin
                            state_q    <= S_WAIT;
                            skew_cnt_q <= {CW{1'b0}};
                        end
                    end
                    S_WAIT: begin
                        if (all_locked_s) begin
                            state_q <= S_ACTIVE;
                        end else if (skew_timeout_s) begin
                            state_q <= S_FAIL;
                        end else begin
                            skew_cnt_q <= skew_cnt_q + CW'(1);
                        end
                    end
                    S_ACTIVE: state_q <= S_ACTIVE;
                    S_FAIL:   state_q <= S_FAIL;
                    default:  state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign sof_o      = sof_q;
    assign offset_o   = offset_q;
    assign err_skew_o = err_q;
endmodule
